// File: rtl/rfg_axis_egress_arbiter_if.sv
// AXI-Stream bundle shared by the egress arbiter and its neighbours.
//   N lanes of 8-bit data with per-lane valid/last/ready, plus a 3-bit
//   stream id. The arbiter uses an N_SRC-lane instance on its requester side
//   and a single-lane instance on its egress side.
//   master : drives tdata/tvalid/tlast/tid, samples tready
//   slave  : samples tdata/tvalid/tlast/tid, drives tready
interface rfg_axis_egress_arbiter_if #(
  parameter int unsigned N = 1
);
  logic [8*N-1:0] tdata;
  logic [N-1:0]   tvalid;
  logic [N-1:0]   tlast;
  logic [N-1:0]   tready;
  logic [2:0]     tid;

  modport master (output tdata, tvalid, tlast, tid, input tready);
  modport slave  (input tdata, tvalid, tlast, tid, output tready);
endinterface

// File: rtl/rfg_axis_egress_arbiter.sv
// Packet-atomic round-robin arbiter sharing the core-clock egress AXIS
// stream between N_SRC requesters, optionally prefixing every packet with a
// one-byte source header {HDR_TAG, source index}.
// Ports:
//   aclk          core clock
//   aresetn       asynchronous active-low reset
//   s_axis        requester side (slave modport), lane i = source i
//   m_axis        egress side (master modport), tid = owner of current beat
//   grant_active  high while a source holds the grant
//   trunc_pulse   high in the cycle a packet is force-terminated at MAX_PKT
module rfg_axis_egress_arbiter #(
  parameter int unsigned N_SRC     = 2,
  parameter bit          HEADER_EN = 1'b1,
  parameter logic [4:0]  HDR_TAG   = 5'b10100,
  parameter int unsigned MAX_PKT   = 256
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  rfg_axis_egress_arbiter_if.slave      s_axis,
  rfg_axis_egress_arbiter_if.master     m_axis,
  output logic                          grant_active,
  output logic                          trunc_pulse
);

  localparam int unsigned CNT_W = $clog2(MAX_PKT);

  typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;

  state_t           state_reg, state_next;
  logic [2:0]       grant_reg;
  logic [2:0]       last_grant_reg;
  logic [CNT_W-1:0] cnt_reg;

  logic             m_valid_reg;
  logic [7:0]       m_data_reg;
  logic             m_last_reg;
  logic [2:0]       m_tid_reg;

  // Requester signals zero-padded to 8 lanes so a 3-bit index never selects
  // outside the vector and unused lanes read as 0 rather than X.
  logic [7:0]  req_pad;
  logic [7:0]  last_pad;
  logic [63:0] data_pad;
  logic [7:0]  ready_pad;

  logic       out_ready;
  logic       pick_valid;
  logic [2:0] pick_idx;
  logic [3:0] idx_sum;
  logic       at_max;
  logic       hdr_load;
  logic       beat_acc;
  logic       pkt_end;

  assign req_pad   = 8'(s_axis.tvalid);
  assign last_pad  = 8'(s_axis.tlast);
  assign data_pad  = 64'(s_axis.tdata);
  assign out_ready = !m_valid_reg || m_axis.tready[0];
  assign at_max    = (cnt_reg == CNT_W'(MAX_PKT - 1));

  // Round-robin search starting just after the previous owner. Scanning from
  // the farthest offset down lets the nearest valid requester win.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    idx_sum    = '0;
    for (int off = N_SRC; off >= 1; off--) begin
      idx_sum = {1'b0, last_grant_reg} + 4'(off);
      if (idx_sum >= 4'(N_SRC)) begin
        idx_sum = idx_sum - 4'(N_SRC);
      end
      if (req_pad[idx_sum[2:0]]) begin
        pick_valid = 1'b1;
        pick_idx   = idx_sum[2:0];
      end
    end
  end

  // State register
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE: begin
        if (pick_valid) begin
          if (HEADER_EN) state_next = HDR;
          else           state_next = DATA;
        end
      end
      HDR:     if (hdr_load) state_next = DATA;
      DATA:    if (pkt_end)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output/control decode
  always_comb begin
    ready_pad   = '0;
    hdr_load    = 1'b0;
    beat_acc    = 1'b0;
    pkt_end     = 1'b0;
    trunc_pulse = 1'b0;
    unique case (state_reg)
      HDR: hdr_load = out_ready;
      DATA: begin
        ready_pad[grant_reg] = out_ready;
        beat_acc    = out_ready && req_pad[grant_reg];
        pkt_end     = beat_acc && (last_pad[grant_reg] || at_max);
        trunc_pulse = beat_acc && !last_pad[grant_reg] && at_max;
      end
      default: ;
    endcase
  end

  // Grant bookkeeping and the single egress output register
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      grant_reg      <= '0;
      last_grant_reg <= 3'(N_SRC - 1);
      cnt_reg        <= '0;
      m_valid_reg    <= 1'b0;
      m_data_reg     <= '0;
      m_last_reg     <= 1'b0;
      m_tid_reg      <= '0;
    end else begin
      if (state_reg == IDLE && pick_valid) begin
        grant_reg <= pick_idx;
      end
      if (pkt_end) begin
        last_grant_reg <= grant_reg;
        cnt_reg        <= '0;
      end else if (beat_acc) begin
        cnt_reg <= cnt_reg + CNT_W'(1);
      end
      if (out_ready) begin
        m_valid_reg <= hdr_load || beat_acc;
        if (hdr_load) begin
          m_data_reg <= {HDR_TAG, grant_reg};
          m_last_reg <= 1'b0;
          m_tid_reg  <= grant_reg;
        end else if (beat_acc) begin
          m_data_reg <= data_pad[{grant_reg, 3'b000} +: 8];
          // A beat taken at the MAX_PKT limit closes the packet downstream
          m_last_reg <= last_pad[grant_reg] || at_max;
          m_tid_reg  <= grant_reg;
        end
      end
    end
  end

  assign s_axis.tready = ready_pad[N_SRC-1:0];
  assign m_axis.tvalid = m_valid_reg;
  assign m_axis.tdata  = m_data_reg;
  assign m_axis.tlast  = m_last_reg;
  assign m_axis.tid    = m_tid_reg;
  assign grant_active  = (state_reg != IDLE);

endmodule
